// File: rtl/i2c_master_csr_mc.sv
// I2C master CSR block: register map, per-channel banks, TX hold entry,
// RX read port, run/watchdog control and interrupt generation.
module i2c_master_csr_mc #(
    parameter int T_ADDR_WID  = 8,
    parameter int P_CLK_FREQ  = 100_000_000,
    parameter int P_I2C_SPEED = 400_000,
    parameter int P_CH_NUM    = 4,
    parameter int P_TMO_WID   = 24,
    parameter int P_RX_DEPTH  = 8,
    parameter int P_TX_DEPTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [T_ADDR_WID-1:0] T_ADDR,
    input  logic                  T_WREN,
    input  logic                  T_RDEN,
    input  logic [31:0]           T_WDATA,
    output logic [31:0]           T_RDATA,
    output logic                  IRQ,
    output logic [31:0]           I2C_CLKDIV,
    output logic                  I2C_RST,
    output logic                  I2C_EN,
    output logic                  I2C_GO,
    input  logic                  I2C_DONE,
    input  logic                  I2C_BUSY,
    output logic [7:0]            I2C_RUN_NUM,
    output logic [2:0]            I2C_SEL,
    output logic [6:0]            I2C_SLAVE_ADDR,
    input  logic                  fifo_snd_rdy,
    output logic                  fifo_snd_vld,
    output logic [7:0]            fifo_snd_dat,
    output logic [4:0]            fifo_snd_ctl,
    input  logic [7:0]            fifo_snd_rooms,
    output logic                  fifo_rcv_rdy,
    input  logic                  fifo_rcv_vld,
    input  logic [7:0]            fifo_rcv_dat,
    input  logic                  fifo_rcv_ack,
    input  logic [7:0]            fifo_rcv_items,
    output logic [3:0]            NUM_CLK_PRE,
    output logic [3:0]            NUM_CLK_MID,
    output logic [3:0]            NUM_CLK_POST,
    output logic [3:0]            NUM_CLK_GAP
);

    localparam logic [31:0] DIV_RST = 32'(P_CLK_FREQ / P_I2C_SPEED);
    localparam logic [31:0] VERSION = 32'h0001_0000;
    localparam logic [7:0]  RXD     = 8'(P_RX_DEPTH);
    localparam logic [7:0]  TXD     = 8'(P_TX_DEPTH);

    localparam logic [T_ADDR_WID-1:0] A_VER = T_ADDR_WID'(8'h00);
    localparam logic [T_ADDR_WID-1:0] A_CTL = T_ADDR_WID'(8'h04);
    localparam logic [T_ADDR_WID-1:0] A_STA = T_ADDR_WID'(8'h08);
    localparam logic [T_ADDR_WID-1:0] A_CFG = T_ADDR_WID'(8'h0C);
    localparam logic [T_ADDR_WID-1:0] A_SEL = T_ADDR_WID'(8'h10);
    localparam logic [T_ADDR_WID-1:0] A_SA  = T_ADDR_WID'(8'h14);
    localparam logic [T_ADDR_WID-1:0] A_DIV = T_ADDR_WID'(8'h28);
    localparam logic [T_ADDR_WID-1:0] A_TMO = T_ADDR_WID'(8'h2C);
    localparam logic [T_ADDR_WID-1:0] A_RUN = T_ADDR_WID'(8'h30);
    localparam logic [T_ADDR_WID-1:0] A_MSK = T_ADDR_WID'(8'h34);
    localparam logic [T_ADDR_WID-1:0] A_THR = T_ADDR_WID'(8'h38);
    localparam logic [T_ADDR_WID-1:0] A_TXD = T_ADDR_WID'(8'h40);
    localparam logic [T_ADDR_WID-1:0] A_RXD = T_ADDR_WID'(8'h50);

    function automatic logic [3:0] nz(input logic [3:0] v);
        return (v == 4'd0) ? 4'd1 : v;
    endfunction

    logic                 en, ie, ctl_rst;
    logic [3:0]           pre, mid, post, gap;
    logic [2:0]           sel;
    logic [6:0]           saddr [8];
    logic [31:0]          cdiv  [8];
    logic [P_TMO_WID-1:0] timeout, wd_cnt, wd_nxt;
    logic                 run_go, run_go_nxt, abort, wd_fire;
    logic [7:0]           run_num, rx_thr;
    logic [4:0]           msk;
    logic                 snd_vld;
    logic [7:0]           snd_dat;
    logic [4:0]           snd_ctl;
    logic                 rcv_rdy, irq;
    logic                 done_ip, tmo, ovf;
    logic [31:0]          rdata, rd_mux, tmo_rd;
    logic                 i2c_rst, i2c_en, i2c_go, rxthr;
    logic                 done_set, tmo_set, ovf_set, clr_all;
    logic [2:0]           w1c;

    logic wr_ctl, wr_sta, wr_cfg, wr_sel, wr_sa, wr_div;
    logic wr_tmo, wr_run, wr_msk, wr_thr, wr_tx, rd_rx, sel_ok;

    assign wr_ctl = T_WREN && (T_ADDR == A_CTL);
    assign wr_sta = T_WREN && (T_ADDR == A_STA);
    assign wr_cfg = T_WREN && (T_ADDR == A_CFG);
    assign wr_sel = T_WREN && (T_ADDR == A_SEL);
    assign wr_sa  = T_WREN && (T_ADDR == A_SA);
    assign wr_div = T_WREN && (T_ADDR == A_DIV);
    assign wr_tmo = T_WREN && (T_ADDR == A_TMO);
    assign wr_run = T_WREN && (T_ADDR == A_RUN);
    assign wr_msk = T_WREN && (T_ADDR == A_MSK);
    assign wr_thr = T_WREN && (T_ADDR == A_THR);
    assign wr_tx  = T_WREN && (T_ADDR == A_TXD);
    assign rd_rx  = T_RDEN && (T_ADDR == A_RXD);
    assign sel_ok = {29'h0, T_WDATA[2:0]} < 32'(P_CH_NUM);

    assign i2c_rst = ctl_rst | ~RESET_N | abort;
    assign i2c_en  = en & ~i2c_rst;
    assign i2c_go  = run_go & i2c_en;
    assign rxthr   = (rx_thr != 8'd0) && (fifo_rcv_items >= rx_thr);

    // Watchdog expires on the GO cycle that takes the count from 1 to 0.
    assign wd_fire = i2c_go & ~I2C_DONE & (wd_cnt == P_TMO_WID'(1));

    always_comb begin
        run_go_nxt = run_go;
        if (wr_run)
            run_go_nxt = T_WDATA[0];
        else if (I2C_DONE | ctl_rst | ~en | wd_fire)
            run_go_nxt = 1'b0;
    end

    always_comb begin
        wd_nxt = wd_cnt;
        if (run_go_nxt & ~run_go)
            wd_nxt = timeout;
        else if (!run_go_nxt)
            wd_nxt = '0;
        else if (i2c_go & ~I2C_DONE & (wd_cnt != '0))
            wd_nxt = wd_cnt - P_TMO_WID'(1);
    end

    assign done_set = i2c_go & I2C_DONE;
    assign tmo_set  = wd_fire;
    assign ovf_set  = wr_tx & snd_vld & ~fifo_snd_rdy;
    assign clr_all  = ctl_rst | ~en;
    assign w1c      = wr_sta ? T_WDATA[3:1] : 3'b000;

    always_comb begin
        tmo_rd = '0;
        tmo_rd[P_TMO_WID-1:0] = timeout;
    end

    always_comb begin
        rd_mux = '0;
        unique case (T_ADDR)
            A_VER: rd_mux = VERSION;
            A_CTL: rd_mux = {ctl_rst, 29'h0, ie, en};
            A_STA: rd_mux = {i2c_rst, I2C_BUSY, 6'h0, RXD, TXD, 3'h0,
                             rxthr, ovf, tmo, done_ip, en};
            A_CFG: rd_mux = {16'h0, gap, post, mid, pre};
            A_SEL: rd_mux = {29'h0, sel};
            A_SA:  rd_mux = {25'h0, saddr[sel]};
            A_DIV: rd_mux = cdiv[sel];
            A_TMO: rd_mux = tmo_rd;
            A_RUN: rd_mux = {run_num, fifo_rcv_items, fifo_snd_rooms,
                             5'h0, tmo, I2C_DONE, run_go};
            A_MSK: rd_mux = {27'h0, msk};
            A_THR: rd_mux = {24'h0, rx_thr};
            A_TXD: rd_mux = {19'h0, snd_ctl, snd_dat};
            A_RXD: rd_mux = fifo_rcv_vld ?
                            {1'b0, 22'h0, fifo_rcv_ack, fifo_rcv_dat} :
                            32'h8000_0000;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            en      <= 1'b0;
            ie      <= 1'b0;
            ctl_rst <= 1'b0;
            pre     <= 4'd1;
            mid     <= 4'd1;
            post    <= 4'd1;
            gap     <= 4'd1;
            sel     <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                saddr[i] <= 7'd0;
                cdiv[i]  <= DIV_RST;
            end
            timeout <= '0;
            wd_cnt  <= '0;
            run_go  <= 1'b0;
            run_num <= 8'd0;
            abort   <= 1'b0;
            msk     <= 5'd0;
            rx_thr  <= 8'd0;
            snd_vld <= 1'b0;
            snd_dat <= 8'd0;
            snd_ctl <= 5'd0;
            rcv_rdy <= 1'b0;
            rdata   <= 32'd0;
            irq     <= 1'b0;
            done_ip <= 1'b0;
            tmo     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (wr_ctl) begin
                en      <= T_WDATA[0] & ~T_WDATA[31];
                ie      <= T_WDATA[1];
                ctl_rst <= T_WDATA[31];
            end
            if (wr_cfg) begin
                pre  <= nz(T_WDATA[3:0]);
                mid  <= nz(T_WDATA[7:4]);
                post <= nz(T_WDATA[11:8]);
                gap  <= nz(T_WDATA[15:12]);
            end
            if (wr_sel && !I2C_BUSY && sel_ok)
                sel <= T_WDATA[2:0];
            if (wr_sa)
                saddr[sel] <= T_WDATA[6:0];
            if (wr_div)
                cdiv[sel] <= T_WDATA;
            if (wr_tmo)
                timeout <= T_WDATA[P_TMO_WID-1:0];
            if (wr_msk)
                msk <= T_WDATA[4:0];
            if (wr_thr)
                rx_thr <= T_WDATA[7:0];
            if (wr_run)
                run_num <= T_WDATA[31:24];
            run_go <= run_go_nxt;
            wd_cnt <= wd_nxt;
            abort  <= wd_fire;

            // Single hold entry: a write into a stalled entry is lost.
            if (wr_tx && !(snd_vld && !fifo_snd_rdy)) begin
                snd_vld <= 1'b1;
                snd_dat <= T_WDATA[7:0];
                snd_ctl <= T_WDATA[12:8];
            end else if (snd_vld && fifo_snd_rdy) begin
                snd_vld <= 1'b0;
            end

            rcv_rdy <= rd_rx & fifo_rcv_vld;
            rdata   <= T_RDEN ? rd_mux : 32'd0;
            irq     <= ie & |(msk[4:1] & {rxthr, ovf, tmo, done_ip});

            if (clr_all)       done_ip <= 1'b0;
            else if (done_set) done_ip <= 1'b1;
            else if (w1c[0])   done_ip <= 1'b0;

            if (clr_all)       tmo <= 1'b0;
            else if (tmo_set)  tmo <= 1'b1;
            else if (w1c[1])   tmo <= 1'b0;

            if (clr_all)       ovf <= 1'b0;
            else if (ovf_set)  ovf <= 1'b1;
            else if (w1c[2])   ovf <= 1'b0;
        end
    end

    assign T_RDATA        = rdata;
    assign IRQ            = irq;
    assign I2C_CLKDIV     = cdiv[sel];
    assign I2C_RST        = i2c_rst;
    assign I2C_EN         = i2c_en;
    assign I2C_GO         = i2c_go;
    assign I2C_RUN_NUM    = run_num;
    assign I2C_SEL        = sel;
    assign I2C_SLAVE_ADDR = saddr[sel];
    assign fifo_snd_vld   = snd_vld;
    assign fifo_snd_dat   = snd_dat;
    assign fifo_snd_ctl   = snd_ctl;
    assign fifo_rcv_rdy   = rcv_rdy;
    assign NUM_CLK_PRE    = pre;
    assign NUM_CLK_MID    = mid;
    assign NUM_CLK_POST   = post;
    assign NUM_CLK_GAP    = gap;

endmodule

// File: tb/tb_i2c_master_csr_mc.sv
// Randomized bench for i2c_master_csr_mc against a behavioural
// model of the register map, channel banks, watchdog and flags.
module tb_i2c_master_csr_mc;

    localparam logic [31:0] DIV = 100_000_000 / 400_000;
    localparam logic [7:0] R_CTL = 8'h04, R_STA = 8'h08, R_CFG = 8'h0C;
    localparam logic [7:0] R_SEL = 8'h10, R_SA = 8'h14, R_DIV = 8'h28;
    localparam logic [7:0] R_TMO = 8'h2C, R_RUN = 8'h30, R_MSK = 8'h34;
    localparam logic [7:0] R_THR = 8'h38, R_TXD = 8'h40, R_RXD = 8'h50;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [7:0]  T_ADDR;
    logic        T_WREN, T_RDEN;
    logic [31:0] T_WDATA, T_RDATA;
    logic        IRQ;
    logic [31:0] I2C_CLKDIV;
    logic        I2C_RST, I2C_EN, I2C_GO, I2C_DONE, I2C_BUSY;
    logic [7:0]  I2C_RUN_NUM;
    logic [2:0]  I2C_SEL;
    logic [6:0]  I2C_SLAVE_ADDR;
    logic        fifo_snd_rdy, fifo_snd_vld;
    logic [7:0]  fifo_snd_dat;
    logic [4:0]  fifo_snd_ctl;
    logic [7:0]  fifo_snd_rooms;
    logic        fifo_rcv_rdy, fifo_rcv_vld, fifo_rcv_ack;
    logic [7:0]  fifo_rcv_dat, fifo_rcv_items;
    logic [3:0]  NUM_CLK_PRE, NUM_CLK_MID, NUM_CLK_POST, NUM_CLK_GAP;

    int n_chk = 0;
    int n_err = 0;
    int n_pulse = 0;

    logic [6:0]  m_sa [4];
    logic [31:0] m_cd [4];
    int          m_sel;
    logic [31:0] d, v;
    logic [15:0] cfg_exp;
    logic [7:0]  rn, it, rm, thr;
    int          op, busy, tval, n_go, n_rs, first_rs, p0;
    logic        rv, ra;

    i2c_master_csr_mc dut (
        .CLK(CLK), .RESET_N(RESET_N), .T_ADDR(T_ADDR),
        .T_WREN(T_WREN), .T_RDEN(T_RDEN), .T_WDATA(T_WDATA),
        .T_RDATA(T_RDATA), .IRQ(IRQ), .I2C_CLKDIV(I2C_CLKDIV),
        .I2C_RST(I2C_RST), .I2C_EN(I2C_EN), .I2C_GO(I2C_GO),
        .I2C_DONE(I2C_DONE), .I2C_BUSY(I2C_BUSY),
        .I2C_RUN_NUM(I2C_RUN_NUM), .I2C_SEL(I2C_SEL),
        .I2C_SLAVE_ADDR(I2C_SLAVE_ADDR),
        .fifo_snd_rdy(fifo_snd_rdy), .fifo_snd_vld(fifo_snd_vld),
        .fifo_snd_dat(fifo_snd_dat), .fifo_snd_ctl(fifo_snd_ctl),
        .fifo_snd_rooms(fifo_snd_rooms), .fifo_rcv_rdy(fifo_rcv_rdy),
        .fifo_rcv_vld(fifo_rcv_vld), .fifo_rcv_dat(fifo_rcv_dat),
        .fifo_rcv_ack(fifo_rcv_ack), .fifo_rcv_items(fifo_rcv_items),
        .NUM_CLK_PRE(NUM_CLK_PRE), .NUM_CLK_MID(NUM_CLK_MID),
        .NUM_CLK_POST(NUM_CLK_POST), .NUM_CLK_GAP(NUM_CLK_GAP)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (fifo_rcv_rdy) n_pulse++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] x);
        T_ADDR = a; T_WDATA = x; T_WREN = 1'b1;
        tick();
        T_WREN = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] x);
        T_ADDR = a; T_RDEN = 1'b1;
        tick();
        T_RDEN = 1'b0;
        x = T_RDATA;
    endtask

    function automatic logic [31:0] sta(input logic rx, input logic o,
                                        input logic t, input logic dn,
                                        input logic e);
        return {2'b00, 6'h0, 8'd8, 8'd8, 3'h0, rx, o, t, dn, e};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        RESET_N = 0; T_ADDR = 0; T_WREN = 0; T_RDEN = 0; T_WDATA = 0;
        I2C_DONE = 0; I2C_BUSY = 0; fifo_snd_rdy = 0; fifo_snd_rooms = 0;
        fifo_rcv_vld = 0; fifo_rcv_dat = 0; fifo_rcv_ack = 0;
        fifo_rcv_items = 0;
        for (int i = 0; i < 4; i++) begin m_sa[i] = 0; m_cd[i] = DIV; end
        m_sel = 0;
        tick(3);
        chk("rst_i2c_rst", I2C_RST, 1);
        chk("rst_en", I2C_EN, 0);
        chk("rst_clkdiv", I2C_CLKDIV, DIV);
        chk("rst_numclk", {NUM_CLK_GAP, NUM_CLK_POST, NUM_CLK_MID,
                           NUM_CLK_PRE}, 32'h1111);
        chk("rst_outs", {IRQ, fifo_snd_vld, fifo_rcv_rdy, I2C_GO, I2C_SEL,
                         I2C_SLAVE_ADDR, I2C_RUN_NUM, fifo_snd_dat}, 0);
        chk("rst_rdata", T_RDATA, 0);
        RESET_N = 1;
        tick();
        chk("post_rst_i2c_rst", I2C_RST, 0);

        rd(8'h3C, d);
        chk("unmapped_rd", d, 0);
        rd(R_DIV, d);
        chk("clkdiv_rd", d, DIV);
        tick();
        chk("rdata_idle", T_RDATA, 0);

        // bank select, directed
        wr(R_SEL, 2); wr(R_SA, 32'h50); wr(R_DIV, 250);
        m_sel = 2; m_sa[2] = 7'h50; m_cd[2] = 250;
        chk("bank2_sel", I2C_SEL, 2);
        chk("bank2_sa", I2C_SLAVE_ADDR, 7'h50);
        chk("bank2_div", I2C_CLKDIV, 250);
        wr(R_SEL, 0); m_sel = 0;
        chk("bank0_sa", I2C_SLAVE_ADDR, 0);
        chk("bank0_div", I2C_CLKDIV, DIV);
        wr(R_SEL, 5);
        chk("sel_guard_range", I2C_SEL, 0);
        I2C_BUSY = 1; wr(R_SEL, 1); I2C_BUSY = 0;
        chk("sel_guard_busy", I2C_SEL, 0);

        // bank select, random vs model
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            d = $urandom;
            if (op == 0) begin
                busy = $urandom_range(0, 1);
                I2C_BUSY = busy[0];
                wr(R_SEL, d);
                I2C_BUSY = 0;
                if (busy == 0 && d[2:0] < 3'd4) m_sel = int'(d[2:0]);
            end else if (op == 1) begin
                wr(R_SA, d); m_sa[m_sel] = d[6:0];
            end else begin
                wr(R_DIV, d); m_cd[m_sel] = d;
            end
            chk("rnd_sel", I2C_SEL, m_sel);
            chk("rnd_sa", I2C_SLAVE_ADDR, m_sa[m_sel]);
            chk("rnd_div", I2C_CLKDIV, m_cd[m_sel]);
            rd(R_SA, v);
            chk("rnd_sa_rd", v, {25'h0, m_sa[m_sel]});
        end

        // CONFIG nibbles, zero stored as one
        for (int i = 0; i < 8; i++) begin
            d = 0;
            for (int k = 0; k < 4; k++) begin
                v = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15);
                d = d | (v << (4 * k));
                cfg_exp[4*k +: 4] = (v == 0) ? 4'd1 : v[3:0];
            end
            wr(R_CFG, d);
            chk("cfg_out", {NUM_CLK_GAP, NUM_CLK_POST, NUM_CLK_MID,
                            NUM_CLK_PRE}, cfg_exp);
        end

        wr(R_CTL, 1);
        chk("en_on", I2C_EN, 1);

        // TX hold and overflow
        fifo_snd_rdy = 0;
        wr(R_TXD, 32'h1A5);
        wr(R_TXD, 32'h1B6);
        chk("tx_hold", {fifo_snd_vld, fifo_snd_ctl, fifo_snd_dat},
            {1'b1, 5'h01, 8'hA5});
        rd(R_STA, d);
        chk("tx_ovf_sta", d, sta(0, 1, 0, 0, 1));
        fifo_snd_rdy = 1;
        tick();
        chk("tx_drop", fifo_snd_vld, 0);
        fifo_snd_rdy = 0;
        wr(R_STA, 32'h8);
        rd(R_STA, d);
        chk("ovf_clr", d[3], 0);

        // RX read port
        for (int i = 0; i < 7; i++) begin
            if (i == 0) begin rv = 1; ra = 1; fifo_rcv_dat = 8'h3C; end
            else if (i == 1) begin rv = 0; ra = 0; end
            else begin
                rv = 1'($urandom_range(0, 1));
                ra = 1'($urandom_range(0, 1));
                fifo_rcv_dat = 8'($urandom);
            end
            fifo_rcv_vld = rv; fifo_rcv_ack = ra;
            p0 = n_pulse;
            rd(R_RXD, d);
            chk("rx_data", d, rv ? {23'h0, ra, fifo_rcv_dat} : 32'h8000_0000);
            tick(2);
            chk("rx_pulses", n_pulse - p0, rv ? 1 : 0);
        end
        fifo_rcv_vld = 0;

        // rx threshold level
        for (int i = 0; i < 8; i++) begin
            thr = 8'($urandom_range(0, 8));
            it = 8'($urandom_range(0, 15));
            wr(R_THR, thr);
            fifo_rcv_items = it;
            rd(R_STA, d);
            chk("rxthr", d[4], (thr != 0 && it >= thr) ? 1 : 0);
        end
        wr(R_THR, 0);
        fifo_rcv_items = 0;

        // watchdog
        wr(R_MSK, 32'h4);
        wr(R_CTL, 32'h3);
        for (int r = 0; r < 2; r++) begin
            tval = (r == 0) ? 10 : $urandom_range(2, 20);
            wr(R_TMO, tval);
            wr(R_RUN, 1);
            n_go = 0; n_rs = 0; first_rs = -1;
            for (int k = 0; k < tval + 10; k++) begin
                if (I2C_GO) n_go++;
                if (I2C_RST) begin
                    n_rs++;
                    if (first_rs < 0) first_rs = k;
                end
                tick();
            end
            chk("wd_go_cycles", n_go, tval);
            chk("wd_rst_cycles", n_rs, 1);
            chk("wd_rst_pos", first_rs, tval);
            rd(R_RUN, d);
            chk("wd_run_rd", d, 32'h4);
            rd(R_STA, d);
            chk("wd_sta", d, sta(0, 0, 1, 0, 1));
            chk("wd_irq", IRQ, 1);
            wr(R_STA, 32'h4);
            rd(R_STA, d);
            chk("wd_tmo_clr", d[2], 0);
            tick(2);
            chk("wd_irq_clr", IRQ, 0);
        end

        // TIMEOUT=0 disables the watchdog
        wr(R_TMO, 0);
        wr(R_RUN, 1);
        n_rs = 0;
        for (int k = 0; k < 30; k++) begin
            if (I2C_RST) n_rs++;
            tick();
        end
        chk("wd_off_go", I2C_GO, 1);
        chk("wd_off_rst", n_rs, 0);

        // RUN readback and done
        wr(R_MSK, 32'h2);
        rn = 8'($urandom); it = 8'($urandom); rm = 8'($urandom);
        fifo_rcv_items = it; fifo_snd_rooms = rm;
        wr(R_RUN, {rn, 23'h0, 1'b1});
        chk("run_num", I2C_RUN_NUM, rn);
        rd(R_RUN, d);
        chk("run_rd", d, {rn, it, rm, 5'h0, 3'b001});
        fifo_rcv_items = 0; fifo_snd_rooms = 0;
        I2C_DONE = 1; tick(); I2C_DONE = 0;
        rd(R_STA, d);
        chk("done_sta", d, sta(0, 0, 0, 1, 1));
        rd(R_RUN, d);
        chk("done_run_go", d[0], 0);
        chk("done_irq", IRQ, 1);
        wr(R_STA, 32'h2);
        wr(R_RUN, 1);
        I2C_DONE = 1;
        wr(R_STA, 32'h2);
        I2C_DONE = 0;
        rd(R_STA, d);
        chk("done_set_wins", d[1], 1);
        wr(R_STA, 32'h2);
        rd(R_STA, d);
        chk("done_w1c", d[1], 0);

        // soft reset through CONTROL
        wr(R_CTL, 32'h8000_0001);
        chk("ctl_rst_out", {I2C_RST, I2C_EN}, 2'b10);
        rd(R_CTL, d);
        chk("ctl_rst_rd", d, 32'h8000_0000);
        wr(R_CTL, 32'h1);
        chk("ctl_rel", {I2C_RST, I2C_EN}, 2'b01);

        // reset while a TX entry is held
        fifo_snd_rdy = 0;
        wr(R_TXD, 32'h0FF);
        chk("tx_held", fifo_snd_vld, 1);
        #2 RESET_N = 0;
        #1;
        chk("arst_tx_drop", fifo_snd_vld, 0);
        chk("arst_i2c_rst", I2C_RST, 1);
        tick();
        RESET_N = 1;
        tick();
        chk("arst_after", {fifo_snd_vld, I2C_SEL}, 0);
        chk("arst_div", I2C_CLKDIV, DIV);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
